// File: rtl/adpcm_pkg.sv
// adpcm_pkg: shared types and helpers for the pipelined ADPCM quantizer.
//   - CODE_BITS legal range and width helpers.
//   - stage_pl_t: payload carried between quantizer stages. Fields are sized
//     for the largest supported build (W<=32, STEP_W<=31, CH_BITS<=8,
//     CODE_BITS<=8). Narrower builds zero-extend into them, and synthesis
//     trims the constant upper bits.
//   - dq_lsb(): half-LSB offset that seeds the dequantizer accumulator.
package adpcm_pkg;

    localparam int CODE_BITS_MIN = 2;
    localparam int CODE_BITS_MAX = 8;

    localparam int MAX_W       = 32;
    localparam int MAX_STEP_W  = 31;
    localparam int MAX_CH_BITS = 8;

    localparam int MAG_W  = MAX_W + 1;          // |sample - pred| needs one extra bit
    localparam int ACC_W  = MAX_STEP_W + 1;     // dq magnitude stays below 2*step
    localparam int BITS_W = CODE_BITS_MAX - 1;

    typedef logic [MAX_CH_BITS-1:0] ch_t;
    typedef logic [MAG_W-1:0]       mag_t;
    typedef logic [MAX_STEP_W-1:0]  step_t;
    typedef logic [ACC_W-1:0]       acc_t;
    typedef logic [BITS_W-1:0]      bits_t;

    typedef struct packed {
        ch_t   ch;
        logic  sign;
        mag_t  mag;     // remaining magnitude still to be quantized
        step_t step;
        acc_t  acc;     // dequantized magnitude built so far
        bits_t bits;    // magnitude code bits, MSB first, filled per stage
    } stage_pl_t;

    // Number of magnitude bits (= number of compare/subtract stages).
    function automatic int mag_bits(input int code_bits);
        return code_bits - 1;
    endfunction

    function automatic logic code_bits_legal(input int code_bits);
        return (code_bits >= CODE_BITS_MIN) && (code_bits <= CODE_BITS_MAX);
    endfunction

    // Dequantizer seed: step >> (CODE_BITS-1).
    function automatic step_t dq_lsb(input step_t step, input int code_bits);
        return step >> (code_bits - 1);
    endfunction

endpackage

// File: rtl/adpcm_quant_stage.sv
// adpcm_quant_stage: one compare/subtract/accumulate stage of the quantizer.
// Stage K tests the remaining magnitude against thr = step >> (K-1). On a hit
// it sets code bit (CODE_BITS-1-K), removes thr from the magnitude, and adds
// thr to the dequantized accumulator. Registered output, held while !i_en.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_en         global pipeline advance
//   i_vld, i_pl  valid + payload from the previous stage
//   o_vld, o_pl  registered valid + payload to the next stage
module adpcm_quant_stage
    import adpcm_pkg::*;
#(
    parameter int K         = 1,
    parameter int CODE_BITS = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_en,
    input  logic      i_vld,
    input  stage_pl_t i_pl,
    output logic      o_vld,
    output stage_pl_t o_pl
);

    localparam int BIT_IDX = mag_bits(CODE_BITS) - K;

    step_t     w_thr;
    logic      w_hit;
    stage_pl_t w_nxt;
    logic      r_vld;
    stage_pl_t r_pl;

    // The subtract happens only on a hit, so the magnitude never underflows.
    // step=0 gives thr=0, which always hits and leaves mag/acc unchanged.
    always_comb begin
        w_thr = i_pl.step >> (K - 1);
        w_hit = i_pl.mag >= MAG_W'(w_thr);
        w_nxt = i_pl;
        if (w_hit) begin
            w_nxt.mag           = i_pl.mag - MAG_W'(w_thr);
            w_nxt.acc           = i_pl.acc + ACC_W'(w_thr);
            w_nxt.bits[BIT_IDX] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_pl  <= '0;
        end else if (i_en) begin
            r_vld <= i_vld;
            r_pl  <= w_nxt;
        end
    end

    assign o_vld = r_vld;
    assign o_pl  = r_pl;

endmodule

// File: rtl/adpcm_quant_pipe.sv
// adpcm_quant_pipe: pipelined ADPCM quantizer. Each beat produces a
// sign+magnitude code of (sample - pred) against the step size, plus the
// dequantized delta. Each beat carries a channel tag through the pipe.
// Pipeline: capture -> CODE_BITS-1 quant stages -> output register. The
// latency is CODE_BITS cycles. One global stall holds every stage, and
// bubbles are not squeezed out.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       input handshake (in_ready = !out_valid || out_ready)
//   in_ch, in_sample,       channel tag, signed sample, signed prediction,
//   in_pred, in_step        unsigned step size
//   out_valid/out_ready     output handshake
//   out_ch, out_code        tag and {sign, magnitude MSB..LSB}
//   out_dq                  signed dequantized delta
// Supported builds: CODE_BITS 2..8, W<=32, STEP_W<=31, CH_BITS<=8.
module adpcm_quant_pipe
    import adpcm_pkg::*;
#(
    parameter int W         = 16,
    parameter int STEP_W    = 15,
    parameter int CODE_BITS = 4,
    parameter int CH_BITS   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_BITS-1:0]       in_ch,
    input  logic signed [W-1:0]      in_sample,
    input  logic signed [W-1:0]      in_pred,
    input  logic [STEP_W-1:0]        in_step,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_BITS-1:0]       out_ch,
    output logic [CODE_BITS-1:0]     out_code,
    output logic signed [STEP_W+1:0] out_dq
);

    localparam int MB = mag_bits(CODE_BITS);

    logic                     w_en;
    logic [CODE_BITS:0]       w_vld_pipe;   // [0] capture, [k] stage k, [CODE_BITS] output
    stage_pl_t [MB:0]         w_pl;
    logic signed [W:0]        w_diff;
    logic [W:0]               w_mag;
    stage_pl_t                w_cap;
    logic                     r_cap_vld;
    stage_pl_t                r_cap;
    stage_pl_t                w_last;
    logic signed [STEP_W+1:0] w_dq_pos;
    logic signed [STEP_W+1:0] w_dq;
    logic                     r_out_vld;
    logic [CH_BITS-1:0]       r_out_ch;
    logic [CODE_BITS-1:0]     r_out_code;
    logic signed [STEP_W+1:0] r_out_dq;
    logic                     w_unused;

    assign w_en     = !r_out_vld || out_ready;
    assign in_ready = w_en;

    // Sign-extend both operands by one bit so the full difference range
    // (e.g. 32767 - (-32768)) is represented without wrap.
    assign w_diff = $signed({in_sample[W-1], in_sample}) - $signed({in_pred[W-1], in_pred});
    assign w_mag  = w_diff[W] ? $unsigned(-w_diff) : $unsigned(w_diff);

    always_comb begin
        w_cap      = '0;
        w_cap.ch   = MAX_CH_BITS'(in_ch);
        w_cap.sign = w_diff[W];
        w_cap.mag  = MAG_W'(w_mag);
        w_cap.step = MAX_STEP_W'(in_step);
        w_cap.acc  = ACC_W'(dq_lsb(MAX_STEP_W'(in_step), CODE_BITS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld <= 1'b0;
            r_cap     <= '0;
        end else if (w_en) begin
            r_cap_vld <= in_valid;
            r_cap     <= w_cap;
        end
    end

    assign w_pl[0]       = r_cap;
    assign w_vld_pipe[0] = r_cap_vld;

    for (genvar k = 1; k <= MB; k++) begin : g_stage
        adpcm_quant_stage #(
            .K         (k),
            .CODE_BITS (CODE_BITS)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_en),
            .i_vld (w_vld_pipe[k-1]),
            .i_pl  (w_pl[k-1]),
            .o_vld (w_vld_pipe[k]),
            .o_pl  (w_pl[k])
        );
    end

    assign w_last   = w_pl[MB];
    assign w_dq_pos = {1'b0, w_last.acc[STEP_W:0]};
    assign w_dq     = w_last.sign ? -w_dq_pos : w_dq_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_ch   <= '0;
            r_out_code <= '0;
            r_out_dq   <= '0;
        end else if (w_en) begin
            r_out_vld  <= w_vld_pipe[MB];
            r_out_ch   <= w_last.ch[CH_BITS-1:0];
            r_out_code <= {w_last.sign, w_last.bits[MB-1:0]};
            r_out_dq   <= w_dq;
        end
    end

    assign w_vld_pipe[CODE_BITS] = r_out_vld;
    assign out_valid             = w_vld_pipe[CODE_BITS];
    assign out_ch                = r_out_ch;
    assign out_code              = r_out_code;
    assign out_dq                = r_out_dq;

    // The residual magnitude, the step, and the unused upper field bits end here.
    assign w_unused = ^w_last;

endmodule

// File: tb/tb_adpcm_quant_pipe.sv
module tb_adpcm_quant_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Stimulus is shared by three builds (CODE_BITS = 2, 4, 8).
    logic                in_valid, out_ready;
    logic [2:0]          in_ch;
    logic signed [15:0]  in_sample, in_pred;
    logic [14:0]         in_step;

    logic                ir2, ir4, ir8, ov2, ov4, ov8;
    logic [2:0]          och2, och4, och8;
    logic [1:0]          code2;
    logic [3:0]          code4;
    logic [7:0]          code8;
    logic signed [16:0]  dq2, dq4, dq8;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int ch; int code; int dq; } exp_t;
    exp_t q2[$], q4[$], q8[$];

    adpcm_quant_pipe #(.W(16), .STEP_W(15), .CODE_BITS(2), .CH_BITS(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_ch(in_ch),
        .in_sample(in_sample), .in_pred(in_pred), .in_step(in_step), .out_valid(ov2),
        .out_ready(out_ready), .out_ch(och2), .out_code(code2), .out_dq(dq2));
    adpcm_quant_pipe #(.W(16), .STEP_W(15), .CODE_BITS(4), .CH_BITS(3)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_ch(in_ch),
        .in_sample(in_sample), .in_pred(in_pred), .in_step(in_step), .out_valid(ov4),
        .out_ready(out_ready), .out_ch(och4), .out_code(code4), .out_dq(dq4));
    adpcm_quant_pipe #(.W(16), .STEP_W(15), .CODE_BITS(8), .CH_BITS(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .in_ch(in_ch),
        .in_sample(in_sample), .in_pred(in_pred), .in_step(in_step), .out_valid(ov8),
        .out_ready(out_ready), .out_ch(och8), .out_code(code8), .out_dq(dq8));

    // Reference: bit-serial successive approximation on plain integers.
    function automatic void ref_quant(input int cb, input int smp, input int prd, input int stp,
                                      output int code, output int dq);
        int diff, mag, acc, thr, bits;
        diff = smp - prd;
        mag  = (diff < 0) ? -diff : diff;
        acc  = stp >> (cb - 1);
        bits = 0;
        for (int k = 1; k < cb; k++) begin
            thr  = stp >> (k - 1);
            bits = bits << 1;
            if (mag >= thr) begin
                bits = bits | 1;
                mag  = mag - thr;
                acc  = acc + thr;
            end
        end
        code = (((diff < 0) ? 1 : 0) << (cb - 1)) | bits;
        dq   = (diff < 0) ? -acc : acc;
    endfunction

    function automatic exp_t expect_now(input int cb);
        exp_t e;
        int   c, d;
        ref_quant(cb, int'(in_sample), int'(in_pred), int'(in_step), c, d);
        e.ch   = int'(in_ch);
        e.code = c;
        e.dq   = d;
        return e;
    endfunction

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q2.delete();
        q4.delete();
        q8.delete();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (ov4 !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", ov4); end
        n_cmp++; if (code4 !== 4'h0) begin n_bad++; $display("FAIL reset_out_code: got %h want 0", code4); end
        n_cmp++; if (dq4 !== 17'sd0) begin n_bad++; $display("FAIL reset_out_dq: got %0d want 0", dq4); end
        n_cmp++; if (och4 !== 3'd0)  begin n_bad++; $display("FAIL reset_out_ch: got %0d want 0", och4); end
        n_cmp++; if (ir4 !== 1'b1)   begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", ir4); end
        @(negedge clk);
    endtask

    // Directed vectors from the worked examples plus step=0 and extreme diff.
    task automatic test_vectors();
        int smp [7];
        int prd [7];
        int stp [7];
        int xc  [7];
        int xd  [7];
        int lat;
        smp = '{1000, -300, 32767, 1234, 5, -5, -32768};
        prd = '{0,    0,    -32768, 1234, 0, 0, 32767};
        stp = '{500,  200,  16,    88,   0, 0, 32767};
        xc  = '{7,    14,   7,     0,    7, 15, 15};
        xd  = '{937, -325,  30,    11,   0, 0, -61436};
        for (int i = 0; i < 7; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_ch     = 3'(i);
            in_sample = 16'(smp[i]);
            in_pred   = 16'(prd[i]);
            in_step   = 15'(stp[i]);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 0;
            while (ov4 !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL vec%0d_latency: got %0d want 4", i, lat); end
            n_cmp++; if (code4 !== 4'(xc[i])) begin n_bad++; $display("FAIL vec%0d_code: got %b want %b", i, code4, 4'(xc[i])); end
            n_cmp++; if (dq4 !== 17'(xd[i])) begin n_bad++; $display("FAIL vec%0d_dq: got %0d want %0d", i, dq4, xd[i]); end
            n_cmp++; if (och4 !== 3'(i)) begin n_bad++; $display("FAIL vec%0d_ch: got %0d want %0d", i, och4, i); end
            @(negedge clk);
        end
    endtask

    // 8 beats on ch 0..7 with a 5-cycle out_ready gap while the pipe is full.
    task automatic test_back_to_back();
        logic signed [15:0] bs [8];
        logic signed [15:0] bp [8];
        logic [14:0]        bst [8];
        int   sent, got, c;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            bs[i]  = 16'($urandom);
            bp[i]  = 16'($urandom);
            bst[i] = 15'($urandom);
        end
        sent = 0; got = 0; c = 0;
        while ((sent < 8 || got < 8) && c < 80) begin
            out_ready = !(c >= 6 && c < 11);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_ch     = 3'(sent);
                in_sample = bs[sent];
                in_pred   = bp[sent];
                in_step   = bst[sent];
            end
            #1;
            if (ov4 && !out_ready) begin
                n_cmp++; if (ir4 !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_in_ready: got %b want 0 (cyc %0d)", ir4, c); end
            end
            if (out_ready) begin
                n_cmp++; if (ir4 !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 1 (cyc %0d)", ir4, c); end
            end
            if (ov4 && out_ready) begin
                n_cmp++;
                if (q4.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra_output: ch=%0d code=%b", och4, code4);
                end else begin
                    e = q4.pop_front();
                    if (och4 !== 3'(e.ch) || code4 !== 4'(e.code) || dq4 !== 17'(e.dq)) begin
                        n_bad++;
                        $display("FAIL b2b_beat%0d: got ch=%0d code=%b dq=%0d want ch=%0d code=%b dq=%0d",
                                 got, och4, code4, dq4, e.ch, 4'(e.code), e.dq);
                    end
                end
                got++;
            end
            if (in_valid && ir4) begin
                q4.push_back(expect_now(4));
                sent++;
            end
            @(negedge clk);
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got != 8 || sent != 8 || q4.size() != 0) begin
            n_bad++; $display("FAIL b2b_count: got sent=%0d recv=%0d left=%0d want 8/8/0", sent, got, q4.size());
        end
    endtask

    // Reset pulse with 3 beats in flight (one parked at the output).
    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_ch     = 3'(i + 4);
            in_sample = 16'($urandom);
            in_pred   = 16'($urandom);
            in_step   = 15'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (ov4 !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid: got %b want 1", ov4); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL rstmid_async_valid: got %b want 0", ov4); end
        n_cmp++;
        if (code4 !== 4'h0 || dq4 !== 17'sd0 || och4 !== 3'd0) begin
            n_bad++; $display("FAIL rstmid_async_data: got code=%b dq=%0d ch=%0d want 0/0/0", code4, dq4, och4);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale_output: got valid=%b want 0 (cyc %0d)", ov4, i); end
        end
        in_valid  = 1'b1;
        in_ch     = 3'd6;
        in_sample = 16'sd2000;
        in_pred   = 16'sd150;
        in_step   = 15'd1000;
        e = expect_now(4);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (ov4 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL rstmid_next_latency: got %0d want 4", lat); end
        n_cmp++;
        if (och4 !== 3'(e.ch) || code4 !== 4'(e.code) || dq4 !== 17'(e.dq)) begin
            n_bad++;
            $display("FAIL rstmid_next_beat: got ch=%0d code=%b dq=%0d want ch=%0d code=%b dq=%0d",
                     och4, code4, dq4, e.ch, 4'(e.code), e.dq);
        end
        @(negedge clk);
    endtask

    // Random traffic with random back-pressure on all three builds.
    task automatic test_random(input int n);
        int   a2, a8, cyc;
        exp_t e;
        a2 = 0; a8 = 0; cyc = 0;
        while ((a2 < n || a8 < n || q2.size() != 0 || q4.size() != 0 || q8.size() != 0) && cyc < 40000) begin
            if (a2 < n || a8 < n) begin
                in_valid  = ($urandom_range(0, 4) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                in_ch     = 3'($urandom);
                in_sample = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 16'sh7fff : 16'sh8000) : 16'($urandom);
                in_pred   = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 16'sh7fff : 16'sh8000) : 16'($urandom);
                case ($urandom_range(0, 9))
                    0:       in_step = 15'd0;
                    1:       in_step = 15'h7fff;
                    2:       in_step = 15'($urandom_range(0, 64));
                    default: in_step = 15'($urandom);
                endcase
                if ($urandom_range(0, 15) == 0) in_pred = in_sample;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (ov2 && out_ready) begin
                n_cmp++;
                if (q2.size() == 0) begin n_bad++; $display("FAIL rand2_extra_output: code=%b", code2); end
                else begin
                    e = q2.pop_front();
                    if (och2 !== 3'(e.ch) || code2 !== 2'(e.code) || dq2 !== 17'(e.dq)) begin
                        n_bad++;
                        $display("FAIL rand2_beat: got ch=%0d code=%b dq=%0d want ch=%0d code=%b dq=%0d",
                                 och2, code2, dq2, e.ch, 2'(e.code), e.dq);
                    end
                end
            end
            if (ov4 && out_ready) begin
                n_cmp++;
                if (q4.size() == 0) begin n_bad++; $display("FAIL rand4_extra_output: code=%b", code4); end
                else begin
                    e = q4.pop_front();
                    if (och4 !== 3'(e.ch) || code4 !== 4'(e.code) || dq4 !== 17'(e.dq)) begin
                        n_bad++;
                        $display("FAIL rand4_beat: got ch=%0d code=%b dq=%0d want ch=%0d code=%b dq=%0d",
                                 och4, code4, dq4, e.ch, 4'(e.code), e.dq);
                    end
                end
            end
            if (ov8 && out_ready) begin
                n_cmp++;
                if (q8.size() == 0) begin n_bad++; $display("FAIL rand8_extra_output: code=%b", code8); end
                else begin
                    e = q8.pop_front();
                    if (och8 !== 3'(e.ch) || code8 !== 8'(e.code) || dq8 !== 17'(e.dq)) begin
                        n_bad++;
                        $display("FAIL rand8_beat: got ch=%0d code=%b dq=%0d want ch=%0d code=%b dq=%0d",
                                 och8, code8, dq8, e.ch, 8'(e.code), e.dq);
                    end
                end
            end
            if (in_valid && ir2) begin q2.push_back(expect_now(2)); a2++; end
            if (in_valid && ir4) q4.push_back(expect_now(4));
            if (in_valid && ir8) begin q8.push_back(expect_now(8)); a8++; end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc >= 40000 || a2 < n || a8 < n) begin
            n_bad++; $display("FAIL rand_timeout: got accepts %0d/%0d in %0d cycles want %0d each", a2, a8, cyc, n);
        end
        n_cmp++;
        if (q2.size() != 0 || q4.size() != 0 || q8.size() != 0) begin
            n_bad++; $display("FAIL rand_drain: got left %0d/%0d/%0d want 0/0/0", q2.size(), q4.size(), q8.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_ch     = '0;
        in_sample = '0;
        in_pred   = '0;
        in_step   = '0;
        apply_reset();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        apply_reset();
        test_random(10000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
